cond_qualifier: RTL and testbench
=================================

# cond_qualifier

Parametrised, registered condition unit for the OVERTURE condition library. It compares a signed input against zero under one of eight run-time selectable conditions. It qualifies the result over a programmable number of consecutive cycles and can hold the result sticky until cleared. It also counts qualified events. It replaces the fixed single-condition, width-8, combinational condition blocks wherever branch or flag logic needs a glitch-free, debounced or latched condition.

## Interface
- BIT_WIDTH, 8: width of `Input`, two's complement; must be ≥ 2.
- QUAL_DEPTH, 1: number of consecutive enabled true samples required before the condition is qualified; must be ≥ 1.
- CNT_WIDTH, 8: width of the event counter.
- UUID, 0 and NAME, "": identification only; no effect on behaviour.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state immediately.
- Input  in  BIT_WIDTH  signed value under test.
- Mode  in  3  condition select: 0 never, 1 ==0, 2 <0, 3 ≤0, 4 always, 5 ≠0, 6 ≥0, 7 >0.
- Toggle  in  1  enable; low suspends evaluation and forces `Output` low.
- Sticky  in  1  1 makes `Output` report the latched flag; 0 makes it report the live qualified flag.
- Clear  in  1  synchronous clear of the sticky flag and the event counter.
- Output  out  1  condition result.
- Count  out  CNT_WIDTH  number of qualification events, saturating.

## Operation
- Combinational term `cond`, sign bit `s = Input[BIT_WIDTH-1]`, zero flag `z = (Input == 0)`:
  - mode 1: `z`
  - mode 2: `s`
  - mode 3: `s | z`
  - mode 5: `!z`
  - mode 6: `!s`
  - mode 7: `!s & !z`
  - mode 0: 0
  - mode 4: 1
- Run counter `run` has width clog2(QUAL_DEPTH+1). Each edge it updates as follows:
  - Toggle=0 → `run` = 0.
  - Toggle=1 and cond=0 → `run` = 0.
  - Toggle=1 and cond=1 → `run` = min(`run`+1, QUAL_DEPTH).
  - The counter saturates and never wraps.
- `qual = (run == QUAL_DEPTH)`. `qual_d` is `qual` registered one edge.
- Rising event `rise = qual & !qual_d`. It is high for exactly one cycle per qualification.
- Sticky flag `stk`, updated each edge:
  - Clear=1 → 0. Clear wins over a simultaneous rise.
  - Otherwise `rise` → 1.
  - Otherwise it holds.
  - `stk` holds while Toggle=0.
- Event counter `Count`, updated each edge:
  - Clear=1 → 0. Clear wins over a simultaneous rise.
  - Otherwise `rise` → +1, saturating at 2^CNT_WIDTH−1.
- Registered enable: `en_q <= Toggle`.
- `Output = en_q & (Sticky ? stk : qual)`.
- `Output` is glitch-free: it depends only on registered state plus the static `Sticky` select.
- `Mode` and `Sticky` may change at any time:
  - A `Mode` change takes effect at the next edge.
  - Changing `Mode` does not reset `run`. If the new condition is false, `run` clears at the next edge.

## Timing
- Reset values: `run`=0, `qual_d`=0, `stk`=0, `Count`=0, `en_q`=0, so `Output`=0.
- Asserting `rst` mid-qualification discards the partial run; there is no recovery.
- Latency to `Output` high, when the condition is continuously true with Toggle=1: QUAL_DEPTH edges after the first true sample.
  - With QUAL_DEPTH=1, true sampled at edge N gives `Output` high from edge N to N+1.
- Deassertion with Sticky=0: a false sample at edge M drops `Output` after edge M, one cycle of latency.
- Toggle low sampled at edge M: `Output` low after edge M.
- Toggle re-raised: qualification restarts from `run`=0.
- `Count` increments on the edge after `qual` first rises, i.e. one cycle after `Output` rises with Sticky=0.
- A single false or disabled sample anywhere inside a run restarts the run.

## Test plan
- Reset, and QUAL_DEPTH=1 condition sweep: BIT_WIDTH=8, rst pulsed mid-run → `Output`=0 and `Count`=0 immediately. Then Toggle=1, Sticky=0, Input ∈ {0x80, 0xFF, 0x00, 0x01, 0x7F} under each Mode 0–7 → `Output` one cycle later matches the table above. Example: Mode 2 with 0x80 → 1; Mode 7 with 0x00 → 0.
- Qualification: QUAL_DEPTH=3, Mode 1, Input=0 for 2 cycles, then 5 for 1 cycle, then 0 for 4 cycles → `Output` stays low through the broken run. It rises exactly 3 cycles after the restart and stays high. `Count` = 1.
- Sticky and Clear: Sticky=1, Mode 5, Input=3 for 1 cycle, then 0 → `Output` stays 1. Clear pulsed together with a new rise → `stk`=0 and `Count`=0. The next rise sets `stk`=1 and `Count`=1.
- Toggle gating: with qualification active, drop Toggle for 1 cycle → `Output` low the next cycle and `run` cleared. After Toggle=1, `Output` returns only after QUAL_DEPTH cycles. `stk` value is preserved through the gap.
- Count saturation: CNT_WIDTH=2, produce 5 separate qualification events → `Count` sequence 1, 2, 3, 3, 3.
- Width generalisation: BIT_WIDTH=16, Mode 3, Input=0x8000 → 1; Input=0x0000 → 1; Input=0x0001 → 0.

Source files
------------

// File: rtl/cond_qualifier.sv
// Registered sign/zero condition unit: qualifies a selectable compare-against-zero over
// QUAL_DEPTH consecutive enabled samples, optionally latches it, and counts qualification events.
module cond_qualifier #(
  parameter int    BIT_WIDTH  = 8,
  parameter int    QUAL_DEPTH = 1,
  parameter int    CNT_WIDTH  = 8,
  parameter int    UUID       = 0,
  parameter string NAME       = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] Input,
  input  logic [2:0]           Mode,
  input  logic                 Toggle,
  input  logic                 Sticky,
  input  logic                 Clear,
  output logic                 Output,
  output logic [CNT_WIDTH-1:0] Count
);

  localparam int               RUN_W   = $clog2(QUAL_DEPTH + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(QUAL_DEPTH);

  typedef enum logic [2:0] {
    MODE_NEVER  = 3'd0,
    MODE_EQ     = 3'd1,
    MODE_LT     = 3'd2,
    MODE_LE     = 3'd3,
    MODE_ALWAYS = 3'd4,
    MODE_NE     = 3'd5,
    MODE_GE     = 3'd6,
    MODE_GT     = 3'd7
  } mode_t;

  logic             sgn;
  logic             zro;
  logic             cond;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_nxt;
  logic             qual;
  logic             qual_d;
  logic             rise;
  logic             stk;
  logic             en_q;

  assign sgn = Input[BIT_WIDTH-1];
  assign zro = (Input == '0);

  always_comb begin
    cond = 1'b0;
    case (mode_t'(Mode))
      MODE_NEVER:  cond = 1'b0;
      MODE_EQ:     cond = zro;
      MODE_LT:     cond = sgn;
      MODE_LE:     cond = sgn | zro;
      MODE_ALWAYS: cond = 1'b1;
      MODE_NE:     cond = ~zro;
      MODE_GE:     cond = ~sgn;
      MODE_GT:     cond = ~sgn & ~zro;
      default:     cond = 1'b0;
    endcase
  end

  // Any disabled or false sample restarts the run; a full run saturates rather than wrapping.
  always_comb begin
    run_nxt = '0;
    if (Toggle && cond) begin
      if (run == RUN_MAX) begin
        run_nxt = RUN_MAX;
      end else begin
        run_nxt = run + RUN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run    <= '0;
      qual_d <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      run    <= run_nxt;
      qual_d <= qual;
      en_q   <= Toggle;
    end
  end

  assign qual = (run == RUN_MAX);
  assign rise = qual & ~qual_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stk <= 1'b0;
    end else if (Clear) begin
      stk <= 1'b0;
    end else if (rise) begin
      stk <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Count <= '0;
    end else if (Clear) begin
      Count <= '0;
    end else if (rise && (Count != {CNT_WIDTH{1'b1}})) begin
      Count <= Count + CNT_WIDTH'(1);
    end
  end

  // Only registered state feeds Output, so it cannot glitch on Input/Mode changes.
  assign Output = en_q & (Sticky ? stk : qual);

endmodule

// File: tb/tb_cond_qualifier.sv
// Directed bench for cond_qualifier: three instances cover depth-1 sweep, depth-3 qualification
// with a 2-bit counter, and a 16-bit input.
module tb_cond_qualifier;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  a_input;
  logic [2:0]  a_mode;
  logic        a_toggle, a_sticky, a_clear, a_output;
  logic [7:0]  a_count;

  logic [7:0]  b_input;
  logic [2:0]  b_mode;
  logic        b_toggle, b_sticky, b_clear, b_output;
  logic [1:0]  b_count;

  logic [15:0] c_input;
  logic [2:0]  c_mode;
  logic        c_toggle, c_sticky, c_clear, c_output;
  logic [7:0]  c_count;

  cond_qualifier #(.BIT_WIDTH(8), .QUAL_DEPTH(1), .CNT_WIDTH(8), .UUID(1), .NAME("a")) u_a (
    .clk(clk), .rst(rst), .Input(a_input), .Mode(a_mode), .Toggle(a_toggle),
    .Sticky(a_sticky), .Clear(a_clear), .Output(a_output), .Count(a_count)
  );

  cond_qualifier #(.BIT_WIDTH(8), .QUAL_DEPTH(3), .CNT_WIDTH(2), .UUID(2), .NAME("b")) u_b (
    .clk(clk), .rst(rst), .Input(b_input), .Mode(b_mode), .Toggle(b_toggle),
    .Sticky(b_sticky), .Clear(b_clear), .Output(b_output), .Count(b_count)
  );

  cond_qualifier #(.BIT_WIDTH(16), .QUAL_DEPTH(1), .CNT_WIDTH(8), .UUID(3), .NAME("c")) u_c (
    .clk(clk), .rst(rst), .Input(c_input), .Mode(c_mode), .Toggle(c_toggle),
    .Sticky(c_sticky), .Clear(c_clear), .Output(c_output), .Count(c_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_input = '0; a_mode = '0; a_toggle = 0; a_sticky = 0; a_clear = 0;
    b_input = '0; b_mode = '0; b_toggle = 0; b_sticky = 0; b_clear = 0;
    c_input = '0; c_mode = '0; c_toggle = 0; c_sticky = 0; c_clear = 0;
    tick(); tick();
    checks++;
    if ({a_output, b_output, c_output} !== 3'b000) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 000", {a_output, b_output, c_output});
    end
    checks++;
    if ({a_count, b_count, c_count} !== 18'd0) begin
      failures++;
      $display("FAIL reset_counts: got a=%0d b=%0d c=%0d expected 0", a_count, b_count, c_count);
    end
    rst = 1'b0;
    a_toggle = 1; a_mode = 3'd4;
    tick();
    checks++;
    if (a_output !== 1'b1) begin
      failures++;
      $display("FAIL prerst_output: got %b expected 1", a_output);
    end
    tick();
    checks++;
    if (a_count !== 8'd1) begin
      failures++;
      $display("FAIL prerst_count: got %0d expected 1", a_count);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (a_output !== 1'b0 || a_count !== 8'd0) begin
      failures++;
      $display("FAIL midrun_reset: got out=%b cnt=%0d expected out=0 cnt=0", a_output, a_count);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_sweep();
    logic [7:0] vals [5];
    logic [4:0] tab  [8];
    logic       exp;
    vals = '{8'h80, 8'hFF, 8'h00, 8'h01, 8'h7F};
    tab  = '{5'b00000, 5'b00100, 5'b11000, 5'b11100, 5'b11111, 5'b11011, 5'b00111, 5'b00011};
    a_toggle = 1; a_sticky = 0; a_clear = 0;
    for (int m = 0; m < 8; m++) begin
      for (int i = 0; i < 5; i++) begin
        a_mode  = 3'(m);
        a_input = vals[i];
        tick();
        exp = tab[m][4-i];
        checks++;
        if (a_output !== exp) begin
          failures++;
          $display("FAIL sweep mode=%0d in=%02h: got %b expected %b", m, vals[i], a_output, exp);
        end
      end
    end
  endtask

  task automatic test_sticky_clear();
    a_sticky = 1; a_mode = 3'd5; a_input = 8'h00; a_clear = 1;
    tick();
    a_clear = 0;
    tick();
    checks++;
    if (a_output !== 1'b0 || a_count !== 8'd0) begin
      failures++;
      $display("FAIL sticky_cleared: got out=%b cnt=%0d expected out=0 cnt=0", a_output, a_count);
    end
    a_input = 8'h03;
    tick();
    checks++;
    if (a_output !== 1'b0) begin
      failures++;
      $display("FAIL sticky_lag: got %b expected 0", a_output);
    end
    a_input = 8'h00;
    tick();
    checks++;
    if (a_output !== 1'b1 || a_count !== 8'd1) begin
      failures++;
      $display("FAIL sticky_set: got out=%b cnt=%0d expected out=1 cnt=1", a_output, a_count);
    end
    tick();
    checks++;
    if (a_output !== 1'b1) begin
      failures++;
      $display("FAIL sticky_hold: got %b expected 1", a_output);
    end
    a_input = 8'h03;
    tick();
    a_clear = 1;
    tick();
    a_clear = 0;
    checks++;
    if (a_output !== 1'b0 || a_count !== 8'd0) begin
      failures++;
      $display("FAIL clear_vs_rise: got out=%b cnt=%0d expected out=0 cnt=0", a_output, a_count);
    end
    a_input = 8'h00;
    tick();
    a_input = 8'h03;
    tick();
    tick();
    checks++;
    if (a_output !== 1'b1 || a_count !== 8'd1) begin
      failures++;
      $display("FAIL sticky_reset_rise: got out=%b cnt=%0d expected out=1 cnt=1", a_output, a_count);
    end
    a_input = 8'h00;
    a_sticky = 0;
    tick();
    checks++;
    if (a_output !== 1'b0) begin
      failures++;
      $display("FAIL live_select: got %b expected 0", a_output);
    end
    a_sticky = 1;
    #1;
    checks++;
    if (a_output !== 1'b1) begin
      failures++;
      $display("FAIL sticky_select: got %b expected 1", a_output);
    end
  endtask

  task automatic test_qualification();
    logic [7:0] ins  [7];
    logic       eout [7];
    logic [1:0] ecnt [7];
    ins  = '{8'd0, 8'd0, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0};
    eout = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ecnt = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    b_toggle = 1; b_sticky = 0; b_mode = 3'd1; b_input = 8'd5; b_clear = 1;
    tick();
    b_clear = 0;
    for (int i = 0; i < 7; i++) begin
      b_input = ins[i];
      tick();
      checks++;
      if (b_output !== eout[i] || b_count !== ecnt[i]) begin
        failures++;
        $display("FAIL qual step=%0d: got out=%b cnt=%0d expected out=%b cnt=%0d",
                 i, b_output, b_count, eout[i], ecnt[i]);
      end
    end
  endtask

  task automatic test_toggle_gating();
    b_toggle = 0;
    tick();
    checks++;
    if (b_output !== 1'b0) begin
      failures++;
      $display("FAIL gate_low: got %b expected 0", b_output);
    end
    b_sticky = 1;
    #1;
    checks++;
    if (b_output !== 1'b0) begin
      failures++;
      $display("FAIL gate_low_sticky: got %b expected 0", b_output);
    end
    b_sticky = 0;
    b_toggle = 1;
    tick();
    checks++;
    if (b_output !== 1'b0) begin
      failures++;
      $display("FAIL gate_restart1: got %b expected 0", b_output);
    end
    b_sticky = 1;
    #1;
    checks++;
    if (b_output !== 1'b1) begin
      failures++;
      $display("FAIL gate_stk_kept: got %b expected 1", b_output);
    end
    b_sticky = 0;
    tick();
    checks++;
    if (b_output !== 1'b0) begin
      failures++;
      $display("FAIL gate_restart2: got %b expected 0", b_output);
    end
    tick();
    checks++;
    if (b_output !== 1'b1 || b_count !== 2'd1) begin
      failures++;
      $display("FAIL gate_requal: got out=%b cnt=%0d expected out=1 cnt=1", b_output, b_count);
    end
    tick();
    checks++;
    if (b_count !== 2'd2) begin
      failures++;
      $display("FAIL gate_count: got %0d expected 2", b_count);
    end
  endtask

  task automatic test_count_saturation();
    logic [1:0] exp [5];
    exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    b_clear = 1;
    tick();
    b_clear = 0;
    checks++;
    if (b_count !== 2'd0) begin
      failures++;
      $display("FAIL sat_clear: got %0d expected 0", b_count);
    end
    for (int k = 0; k < 5; k++) begin
      b_input = 8'd5;
      tick();
      b_input = 8'd0;
      repeat (4) tick();
      checks++;
      if (b_count !== exp[k]) begin
        failures++;
        $display("FAIL sat_event%0d: got %0d expected %0d", k, b_count, exp[k]);
      end
    end
  endtask

  task automatic test_width();
    logic [15:0] vals [5];
    logic        exp  [5];
    vals = '{16'h8000, 16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF};
    exp  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    c_toggle = 1; c_sticky = 0; c_mode = 3'd3;
    for (int i = 0; i < 5; i++) begin
      c_input = vals[i];
      tick();
      checks++;
      if (c_output !== exp[i]) begin
        failures++;
        $display("FAIL width16 in=%04h: got %b expected %b", vals[i], c_output, exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_sticky_clear();
    test_qualification();
    test_toggle_gating();
    test_count_saturation();
    test_width();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
